// File: rtl/ocram_stream_reader.sv
// Avalon-MM read master that streams a block of OCRAM words out as an Avalon-ST packet.
// Optional running checksum output is enabled by defining OCRAM_STREAM_READER_CSUM_EN.
module ocram_stream_reader #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [1:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop
`ifdef OCRAM_STREAM_READER_CSUM_EN
    ,
    output logic [DATA_W-1:0] csum
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    // Stream handshake: a word moves on out_valid && out_ready; while out_valid is
    // high and out_ready low, out_data/out_sop/out_eop hold their values.
    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  emitted;
    logic              inflight;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              issue;
    logic              push;
    logic              pop;

    // A read is only issued when the FIFO has room for it plus any word still in flight.
    assign issue = (state == RUN) && (issued < len_q) &&
                   ((fifo_count + {{PTR_W{1'b0}}, inflight}) < DEPTH_C);
    assign push  = inflight;
    assign pop   = out_valid && out_ready;

    assign mem_chipselect = issue;
    assign mem_address    = base_q + issued[ADDR_W-1:0];
    assign mem_write      = 1'b0;
    assign mem_byteenable = 2'b11;
    assign mem_clken      = 1'b1;

    assign out_valid = (fifo_count != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_sop   = out_valid && (emitted == '0);
    assign out_eop   = out_valid && (emitted == len_q - 1'b1);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            issued     <= '0;
            emitted    <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            done     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                issued <= issued + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                emitted <= emitted + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            base_q  <= base_addr;
                            len_q   <= length;
                            issued  <= '0;
                            emitted <= '0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued == len_q) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last handshake leaves the FIFO empty with nothing in flight.
                    if (pop && (emitted == len_q - 1'b1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OCRAM_STREAM_READER_CSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum <= '0;
        end else if ((state == IDLE) && start) begin
            csum <= '0;
        end else if (pop) begin
            csum <= csum + out_data;
        end
    end
`endif

endmodule
